// File: rtl/inst_prefetch_queue_pkg.sv
// inst_prefetch_queue_pkg
//   Shared definitions for the instruction prefetch queue slice.
//   These are the default bus and data widths, the reset pc constant, and the
//   pointer-width helper used by the queue and its interface.
package inst_prefetch_queue_pkg;

    localparam int unsigned DEFAULT_PC_WIDTH   = 32;
    localparam int unsigned DEFAULT_INST_WIDTH = 32;
    localparam int unsigned DEFAULT_DEPTH      = 4;

    localparam logic [DEFAULT_PC_WIDTH-1:0] RESET_PC = '0;

    // Storage index bits plus one wrap bit.
    function automatic int unsigned ptr_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/inst_prefetch_queue_if.sv
// inst_prefetch_queue_if
//   Fetch-side and decode-side handshake bundle for the prefetch queue.
//   Signals:
//     flush                      branch redirect
//     in_valid / in_ready        fetch handshake
//     in_pc / in_inst            fetched entry
//     out_valid / out_ready      decode handshake
//     out_pc / out_inst          head entry
//     count                      occupancy, 0..DEPTH
//   Modports:
//     master  fetch/decode side that drives the queue
//     slave   the queue itself
interface inst_prefetch_queue_if
    import inst_prefetch_queue_pkg::*;
#(
    parameter int unsigned PC_WIDTH   = DEFAULT_PC_WIDTH,
    parameter int unsigned INST_WIDTH = DEFAULT_INST_WIDTH,
    parameter int unsigned DEPTH      = DEFAULT_DEPTH
);

    logic                       flush;
    logic                       in_valid;
    logic                       in_ready;
    logic [PC_WIDTH-1:0]        in_pc;
    logic [INST_WIDTH-1:0]      in_inst;
    logic                       out_valid;
    logic                       out_ready;
    logic [PC_WIDTH-1:0]        out_pc;
    logic [INST_WIDTH-1:0]      out_inst;
    logic [$clog2(DEPTH):0]     count;

    modport master (
        output flush, in_valid, in_pc, in_inst, out_ready,
        input  in_ready, out_valid, out_pc, out_inst, count
    );

    modport slave (
        input  flush, in_valid, in_pc, in_inst, out_ready,
        output in_ready, out_valid, out_pc, out_inst, count
    );

endinterface

// File: rtl/inst_prefetch_queue_prefetch_ram.sv
// prefetch_ram
//   DEPTH x WIDTH storage for the prefetch queue.
//   It has one synchronous write port and one asynchronous read port.
//   Ports:
//     clk      write clock
//     wr_en    write strobe
//     wr_addr  write index
//     wr_data  write data
//     rd_addr  read index
//     rd_data  read data, combinational
module prefetch_ram #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]         rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/inst_prefetch_queue.sv
// inst_prefetch_queue
//   FIFO of {pc, instruction} pairs between instruction fetch and decode.
//   Flush and reset both empty the queue in one cycle. Storage is not cleared.
//   Ports:
//     clk  clock, rising edge
//     rst  synchronous, active-high reset
//     bus  inst_prefetch_queue_if.slave (fetch/decode handshakes, flush, count)
//   Build option:
//     PREFETCH_BYPASS_EN  when defined, an entry offered to an empty queue is
//                         presented to decode in the same cycle. If decode
//                         takes it, the entry is never written to storage.
module inst_prefetch_queue
    import inst_prefetch_queue_pkg::*;
#(
    parameter int unsigned PC_WIDTH   = DEFAULT_PC_WIDTH,
    parameter int unsigned INST_WIDTH = DEFAULT_INST_WIDTH,
    parameter int unsigned DEPTH      = DEFAULT_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst,
    inst_prefetch_queue_if.slave  bus
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = ptr_width(DEPTH);
    localparam int unsigned EW = PC_WIDTH + INST_WIDTH;

    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [EW-1:0]         rd_data;
    logic                  empty;
    logic                  full;
    logic                  bypass;
    logic                  push;
    logic                  pop;
    logic                  in_ready_c;
    logic                  out_valid_c;
    logic [PC_WIDTH-1:0]   out_pc_c;
    logic [INST_WIDTH-1:0] out_inst_c;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

    always_comb begin
        in_ready_c  = !full && !bus.flush && !rst;
`ifdef PREFETCH_BYPASS_EN
        bypass      = empty && bus.in_valid && !bus.flush && !rst;
`else
        bypass      = 1'b0;
`endif
        out_valid_c = (!empty && !bus.flush) || bypass;
        out_pc_c    = '0;
        out_inst_c  = '0;
        if (bypass) begin
            out_pc_c   = bus.in_pc;
            out_inst_c = bus.in_inst;
        end else if (!empty && !bus.flush) begin
            {out_pc_c, out_inst_c} = rd_data;
        end
        // A bypassed entry that decode accepts is consumed directly and never
        // stored. The pop only ever advances over stored entries.
        pop  = !empty && !bus.flush && bus.out_ready;
        push = bus.in_valid && in_ready_c && !(bypass && bus.out_ready);
    end

    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    prefetch_ram #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk     (clk),
        .wr_en   (push),
        .wr_addr (wr_ptr[AW-1:0]),
        .wr_data ({bus.in_pc, bus.in_inst}),
        .rd_addr (rd_ptr[AW-1:0]),
        .rd_data (rd_data)
    );

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_c;
    assign bus.out_pc    = out_pc_c;
    assign bus.out_inst  = out_inst_c;
    assign bus.count     = wr_ptr - rd_ptr;

endmodule

// File: tb/tb_inst_prefetch_queue.sv
// tb_inst_prefetch_queue
//   Directed bench for inst_prefetch_queue (DEPTH=4, 32-bit pc/inst).
//   Inputs change 1ns after each rising edge. Outputs are sampled 1ns later.
module tb_inst_prefetch_queue;

    logic clk;
    logic rst;
    int unsigned checks;
    int unsigned failures;

    inst_prefetch_queue_if #(.PC_WIDTH(32), .INST_WIDTH(32), .DEPTH(4)) bus ();

    inst_prefetch_queue #(.PC_WIDTH(32), .INST_WIDTH(32), .DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] inst, input logic rdy);
        bus.in_valid  = v;
        bus.in_pc     = pc;
        bus.in_inst   = inst;
        bus.out_ready = rdy;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        bus.flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 1'b0);

        // Reset
        tick();
        tick();
        chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_count", 64'(bus.count), 64'd0);
        chk("rst_out_pc", 64'(bus.out_pc), 64'd0);
        chk("rst_out_inst", 64'(bus.out_inst), 64'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 64'(bus.in_ready), 64'd1);

        // Fill to DEPTH with decode stalled
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'(4 * i), 32'(32'hA0 + i), 1'b0);
            tick();
            chk("fill_count", 64'(bus.count), 64'(i + 1));
            if (i == 0) begin
                chk("latency_out_valid", 64'(bus.out_valid), 64'd1);
                chk("latency_out_pc", 64'(bus.out_pc), 64'h0);
            end
        end
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        #1;
        chk("full_count", 64'(bus.count), 64'd4);
        chk("full_in_ready", 64'(bus.in_ready), 64'd0);

        // Full: a pop does not allow a push in the same cycle
        drive(1'b1, 32'h10, 32'hA4, 1'b1);
        #1;
        chk("full_pop_in_ready", 64'(bus.in_ready), 64'd0);
        chk("full_pop_out_pc", 64'(bus.out_pc), 64'h0);
        chk("full_pop_out_inst", 64'(bus.out_inst), 64'hA0);
        tick();
        chk("after_full_pop_count", 64'(bus.count), 64'd3);
        chk("after_full_pop_in_ready", 64'(bus.in_ready), 64'd1);
        chk("pushpop_out_pc", 64'(bus.out_pc), 64'h4);
        tick();
        chk("pushpop_count", 64'(bus.count), 64'd3);

        // Drain remainder in order: 0x08, 0x0C, 0x10
        drive(1'b0, 32'h0, 32'h0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("drain_out_valid", 64'(bus.out_valid), 64'd1);
            chk("drain_out_pc", 64'(bus.out_pc), 64'(32'h8 + 4 * i));
            chk("drain_out_inst", 64'(bus.out_inst), 64'(32'hA2 + i));
            tick();
        end
        chk("drained_out_valid", 64'(bus.out_valid), 64'd0);
        chk("drained_count", 64'(bus.count), 64'd0);

        // Wrap-around: 10 back-to-back push/pop pairs
        for (int k = 0; k < 10; k++) begin
            drive(1'b1, 32'(32'h200 + 4 * k), 32'(32'hB0 + k), 1'b1);
            #1;
`ifdef PREFETCH_BYPASS_EN
            chk("wrap_out_valid", 64'(bus.out_valid), 64'd1);
            chk("wrap_out_pc", 64'(bus.out_pc), 64'(32'h200 + 4 * k));
            chk("wrap_count", 64'(bus.count), 64'd0);
`else
            if (k > 0) begin
                chk("wrap_out_valid", 64'(bus.out_valid), 64'd1);
                chk("wrap_out_pc", 64'(bus.out_pc), 64'(32'h200 + 4 * (k - 1)));
                chk("wrap_count", 64'(bus.count), 64'd1);
            end else begin
                chk("wrap_first_out_valid", 64'(bus.out_valid), 64'd0);
            end
`endif
            tick();
        end
        drive(1'b0, 32'h0, 32'h0, 1'b1);
        #1;
`ifndef PREFETCH_BYPASS_EN
        chk("wrap_last_out_pc", 64'(bus.out_pc), 64'h224);
        chk("wrap_last_count", 64'(bus.count), 64'd1);
`endif
        tick();
        chk("wrap_end_count", 64'(bus.count), 64'd0);

        // Flush at count=3 with in_valid high
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'(32'h30 + 4 * i), 32'(32'hC0 + i), 1'b0);
            tick();
        end
        chk("preflush_count", 64'(bus.count), 64'd3);
        drive(1'b1, 32'h3C, 32'hC3, 1'b0);
        bus.flush = 1'b1;
        #1;
        chk("flush_in_ready", 64'(bus.in_ready), 64'd0);
        chk("flush_out_valid", 64'(bus.out_valid), 64'd0);
        tick();
        bus.flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        #1;
        chk("postflush_count", 64'(bus.count), 64'd0);
        chk("postflush_out_valid", 64'(bus.out_valid), 64'd0);
        drive(1'b1, 32'h100, 32'hD0, 1'b0);
        tick();
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        #1;
        chk("postflush_first_pc", 64'(bus.out_pc), 64'h100);
        chk("postflush_first_inst", 64'(bus.out_inst), 64'hD0);
        chk("postflush_count1", 64'(bus.count), 64'd1);
        bus.out_ready = 1'b1;
        tick();
        chk("postflush_drained", 64'(bus.count), 64'd0);

        // Reset mid-stream at count=2
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 32'(32'h40 + 4 * i), 32'(32'hE0 + i), 1'b0);
            tick();
        end
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        #1;
        chk("prerst_count", 64'(bus.count), 64'd2);
        rst = 1'b1;
        #1;
        chk("midrst_in_ready", 64'(bus.in_ready), 64'd0);
        tick();
        rst = 1'b0;
        #1;
        chk("midrst_count", 64'(bus.count), 64'd0);
        chk("midrst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("midrst_in_ready_after", 64'(bus.in_ready), 64'd1);

        // Push into empty queue with decode ready
        drive(1'b1, 32'h20, 32'hF0, 1'b1);
        #1;
`ifdef PREFETCH_BYPASS_EN
        chk("byp_out_valid", 64'(bus.out_valid), 64'd1);
        chk("byp_out_pc", 64'(bus.out_pc), 64'h20);
        chk("byp_out_inst", 64'(bus.out_inst), 64'hF0);
`else
        chk("nobyp_out_valid", 64'(bus.out_valid), 64'd0);
`endif
        tick();
        drive(1'b0, 32'h0, 32'h0, 1'b1);
        #1;
`ifdef PREFETCH_BYPASS_EN
        chk("byp_count", 64'(bus.count), 64'd0);
        chk("byp_after_out_valid", 64'(bus.out_valid), 64'd0);
`else
        chk("nobyp_count", 64'(bus.count), 64'd1);
        chk("nobyp_late_out_valid", 64'(bus.out_valid), 64'd1);
        chk("nobyp_late_out_pc", 64'(bus.out_pc), 64'h20);
`endif
        tick();
        chk("final_count", 64'(bus.count), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
